uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameters: CLOCK_FREQ, default 50_000_000, core clock in Hz; BAUD_RATE, default 115_200, serial bit rate.
REQ-002 clk  input  1  single core clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 serial_in  input  1  asynchronous serial line, idle high (board FPGA_SERIAL_RX).
REQ-005 data_out  output  8  received byte, valid only while data_out_valid=1.
REQ-006 data_out_valid  output  1  byte available to the CPU memory-mapped I/O path.
REQ-007 data_out_ready  input  1  consumer accepts the byte on any cycle where valid and ready are both 1.
REQ-008 frame_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.

Function
REQ-010 BIT_CYCLES SHALL be CLOCK_FREQ/BAUD_RATE (integer division) and HALF_CYCLES SHALL be BIT_CYCLES/2; the bit counter width SHALL be clog2(BIT_CYCLES)+1.
REQ-011 serial_in SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal.
REQ-012 States SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: a synchronized low SHALL move to START and clear the bit counter.
REQ-014 START: after HALF_CYCLES cycles, re-sample; low -> DATA with the counter cleared; high -> IDLE (glitch rejected, no flags).
REQ-015 DATA: 8 bits SHALL be sampled LSB first, each BIT_CYCLES after the previous sample, i.e. at mid-bit; after bit 7 -> STOP.
REQ-016 STOP: sample BIT_CYCLES after bit 7; high -> byte complete; low -> frame_error pulses for 1 cycle, byte discarded; both cases -> IDLE.
REQ-017 On byte complete with data_out_valid=0, or with valid=1 and ready=1 in the same cycle, data_out SHALL load the byte and data_out_valid SHALL be 1 on the next cycle.
REQ-018 On byte complete with valid=1 and ready=0, the new byte SHALL be dropped, data_out SHALL be unchanged, and overrun SHALL pulse 1 cycle.
REQ-019 A handshake (valid and ready both 1) with no byte completing SHALL clear data_out_valid on the next cycle.
REQ-020 data_out SHALL stay stable while valid=1 and ready=0.
REQ-021 Reception SHALL continue regardless of data_out_valid; back-to-back frames with no idle gap SHALL be received.
REQ-022 A break (line low for more than 10 bit times) SHALL produce one frame_error, then wait in IDLE until the line returns high before detecting the next start bit.

Reset
REQ-023 On rst: state IDLE, counters 0, synchronizer flops 1, data_out 0, data_out_valid 0, frame_error 0, overrun 0.
REQ-024 rst asserted mid-frame SHALL abandon the frame with no flag pulse; after deassertion the line SHALL be treated as idle until a fresh high-to-low edge.

Structure
REQ-025 State encodings and the BIT_CYCLES/HALF_CYCLES derivation SHALL live in a shared uart_pkg, for reuse by the matching transmitter.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module named synchronizer, parameterized by width.
REQ-027 The block SHALL be instantiated inside Riscv151, driven by FPGA_SERIAL_RX; the MMIO read path consumes data_out, data_out_valid, and data_out_ready.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100 -> BIT_CYCLES=10)
REQ-028 Frame 0x5A, ready held 1 -> data_out=0x5A, valid for exactly 1 cycle, no error flags.
REQ-029 Frames 0xA5 then 0x3C back-to-back, ready=0 -> data_out=0xA5 held; overrun pulses once at 0x3C stop; after ready=1, valid drops.
REQ-030 Frame 0xFF with stop bit driven 0 -> frame_error 1-cycle pulse, valid stays 0; next frame 0x01 received correctly.
REQ-031 Low glitch of 3 cycles on idle line -> returns to IDLE, no valid, no flags.
REQ-032 rst asserted for 1 cycle during bit 4 of 0x81, then clean frame 0x42 -> only 0x42 delivered.
REQ-033 Byte completes in the same cycle a prior byte is accepted (valid=1, ready=1) -> new byte loaded, valid stays 1, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud timing derivation,
// common to the receiver and the matching transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  function automatic int bit_cycles(int clock_freq, int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int half_cycles(int clock_freq, int baud_rate);
    return bit_cycles(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte stream from the UART receiver to its consumer, plus error pulses.
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       frame_error;
  logic       overrun;

  modport master (output data_out, data_out_valid, frame_error, overrun,
                  input  data_out_ready);
  modport slave  (input  data_out, data_out_valid, frame_error, overrun,
                  output data_out_ready);
endinterface

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; resets to RST_VAL.
module synchronizer #(
  parameter int             WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, one-byte holding register with
// valid/ready handoff, frame-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  uart_receiver_if.master   rx
);
  localparam int BIT_CYCLES  = bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_CYCLES = half_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W       = $clog2(BIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

  logic             rx_sync;
  uart_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             armed, armed_n;
  logic [1:0]       settle;
  logic             byte_done, stop_err;

  synchronizer #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_sync)
  );

  // Start detection needs a genuine high first: after reset the synchronizer
  // still holds its reset value for two cycles, and after a framing error
  // (e.g. a break) the line must return high before the next start.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    armed_n   = armed;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_sync && armed)          state_n = START;
        else if (rx_sync && settle[1])  armed_n = 1'b1;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = rx_sync ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_n     = '0;
        shreg_n   = {rx_sync, shreg[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == BIT_LAST) begin
        cnt_n   = '0;
        state_n = IDLE;
        if (rx_sync) byte_done = 1'b1;
        else begin
          stop_err = 1'b1;
          armed_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      shreg             <= '0;
      armed             <= 1'b0;
      settle            <= '0;
      rx.data_out       <= '0;
      rx.data_out_valid <= 1'b0;
      rx.frame_error    <= 1'b0;
      rx.overrun        <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_idx        <= bit_idx_n;
      shreg          <= shreg_n;
      armed          <= armed_n;
      settle         <= {settle[0], 1'b1};
      rx.frame_error <= stop_err;
      rx.overrun     <= 1'b0;
      // A completing byte may replace the held one only if it leaves this cycle.
      if (byte_done) begin
        if (!rx.data_out_valid || rx.data_out_ready) begin
          rx.data_out       <= shreg;
          rx.data_out_valid <= 1'b1;
        end else begin
          rx.overrun <= 1'b1;
        end
      end else if (rx.data_out_valid && rx.data_out_ready) begin
        rx.data_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: serial frames driven bit by bit,
// expected bytes queued at send time, monitor pops on every handshake.
module tb_uart_receiver;
  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int BIT        = CLOCK_FREQ / BAUD_RATE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;

  uart_receiver_if rx_if();

  uart_receiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .rx        (rx_if)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int fe_cnt = 0, ov_cnt = 0, vld_cycles = 0;
  int v0, f0, o0, bad;
  logic [7:0] exp_q[$];
  logic       prev_fe = 1'b0, prev_ov = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // 8N1 frame, LSB first, each bit held for one bit time.
  task automatic send_frame(logic [7:0] b, logic stop_bit);
    serial_in = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(BIT);
    end
    serial_in = stop_bit;
    tick(BIT);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 40 * BIT && exp_q.size() != 0; i++) tick(1);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic snap();
    v0 = vld_cycles;
    f0 = fe_cnt;
    o0 = ov_cnt;
  endtask

  // Monitor: consumes handshakes against the scoreboard, counts flag pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_fe   = 1'b0;
      prev_ov   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (rx_if.data_out_valid) vld_cycles++;
      if (prev_hold) chk("hold_stable", rx_if.data_out, prev_data);
      if (rx_if.data_out_valid && rx_if.data_out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", rx_if.data_out, 256);
        else                   chk("rx_byte", rx_if.data_out, exp_q.pop_front());
      end
      if (rx_if.frame_error) begin
        fe_cnt++;
        chk("fe_pulse_width", int'(prev_fe) + 1, 1);
      end
      if (rx_if.overrun) begin
        ov_cnt++;
        chk("ov_pulse_width", int'(prev_ov) + 1, 1);
      end
      prev_fe   = rx_if.frame_error;
      prev_ov   = rx_if.overrun;
      prev_hold = rx_if.data_out_valid && !rx_if.data_out_ready;
      prev_data = rx_if.data_out;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic good;
    rx_if.data_out_ready = 1'b1;
    tick(4);
    sample();
    chk("rst_data", rx_if.data_out, 0);
    chk("rst_valid", rx_if.data_out_valid, 0);
    chk("rst_fe", rx_if.frame_error, 0);
    chk("rst_ov", rx_if.overrun, 0);
    tick(1);
    rst = 1'b0;
    tick(3);

    // single byte with ready held high: valid lasts exactly one cycle
    snap();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(3);
    drain("5a_drain");
    chk("5a_valid_cycles", vld_cycles - v0, 1);
    chk("5a_fe", fe_cnt - f0, 0);
    chk("5a_ov", ov_cnt - o0, 0);

    // back-to-back with consumer stalled: second byte overruns
    snap();
    rx_if.data_out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(5);
    sample();
    chk("ovr_data_held", rx_if.data_out, 8'hA5);
    chk("ovr_valid_held", rx_if.data_out_valid, 1);
    chk("ovr_count", ov_cnt - o0, 1);
    tick(1);
    rx_if.data_out_ready = 1'b1;
    tick(1);
    sample();
    chk("ovr_valid_drop", rx_if.data_out_valid, 0);
    chk("ovr_drain", exp_q.size(), 0);

    // bad stop bit, then a clean frame
    snap();
    send_frame(8'hFF, 1'b0);
    serial_in = 1'b1;
    tick(BIT);
    chk("fe_count", fe_cnt - f0, 1);
    chk("fe_no_valid", vld_cycles - v0, 0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    tick(3);
    drain("fe_recover");

    // 3-cycle glitch on idle line is rejected
    snap();
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(3 * BIT);
    chk("glitch_valid", vld_cycles - v0, 0);
    chk("glitch_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

    // reset during bit 4 abandons the frame silently
    snap();
    fork
      send_frame(8'h81, 1'b1);
      begin
        tick(5 * BIT + 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    join
    tick(BIT);
    chk("rstmid_valid", vld_cycles - v0, 0);
    chk("rstmid_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    tick(3);
    drain("rstmid_42");

    // break: one frame error, then recovery once the line goes high
    snap();
    serial_in = 1'b0;
    tick(25 * BIT);
    serial_in = 1'b1;
    tick(2 * BIT);
    chk("break_fe", fe_cnt - f0, 1);
    chk("break_valid", vld_cycles - v0, 0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    tick(3);
    drain("break_recover");

    // completion coincides with acceptance of the held byte. The stop sample
    // lands 2 synchronizer cycles + 1 detect cycle + half bit + 9 bits after
    // the start edge; ready is high for exactly that cycle.
    snap();
    rx_if.data_out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(BIT);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        tick(2 + BIT / 2 + 9 * BIT);
        rx_if.data_out_ready = 1'b1;
        tick(1);
        rx_if.data_out_ready = 1'b0;
        sample();
        chk("same_cycle_valid", rx_if.data_out_valid, 1);
        chk("same_cycle_data", rx_if.data_out, 8'h22);
        chk("same_cycle_ov", ov_cnt - o0, 0);
      end
    join
    rx_if.data_out_ready = 1'b1;
    drain("same_cycle_drain");

    // random frames, random gaps (including none), occasional bad stop bit
    snap();
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      if (good) exp_q.push_back(b);
      else      bad++;
      send_frame(b, good);
      serial_in = 1'b1;
      tick(good ? $urandom_range(0, BIT) : $urandom_range(2, BIT));
    end
    tick(2 * BIT);
    drain("rand_drain");
    chk("rand_fe", fe_cnt - f0, bad);
    chk("rand_ov", ov_cnt - o0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
